// File: rtl/mul_share_if.sv
// Request/grant and result bus between the two ALU requesters, the consumer and
// the shared multiplier arbiter.
interface mul_share_if #(
    parameter int unsigned SIZE = 4
) ();
    logic            req0;
    logic [SIZE-1:0] a0;
    logic [SIZE-1:0] b0;
    logic            gnt0;
    logic            req1;
    logic [SIZE-1:0] a1;
    logic [SIZE-1:0] b1;
    logic            gnt1;
    logic            res_valid;
    logic            res_id;
    logic [SIZE-1:0] res_out;
    logic            res_cout;
    logic            res_overflow;
    logic            res_ack;
    logic            busy;

    modport master (
        output req0, a0, b0, req1, a1, b1, res_ack,
        input  gnt0, gnt1, res_valid, res_id, res_out, res_cout, res_overflow, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1, res_ack,
        output gnt0, gnt1, res_valid, res_id, res_out, res_cout, res_overflow, busy
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one registered SIZE-bit multiplier between two
// requesters; one transaction in flight, result held until acknowledged.
module mul_share_arbiter #(
    parameter int unsigned SIZE = 4
) (
    input  logic      clk,
    input  logic      rst,
    mul_share_if.slave bus
);
    localparam int unsigned PW  = 2 * SIZE;
    localparam int unsigned MSB = SIZE - 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] op_a, op_a_nxt;
    logic [SIZE-1:0] op_b, op_b_nxt;
    logic            cur_id, cur_id_nxt;
    logic            last, last_nxt;
    logic            gnt0, gnt0_nxt;
    logic            gnt1, gnt1_nxt;
    logic            res_valid, res_valid_nxt;
    logic            res_id, res_id_nxt;
    logic [SIZE-1:0] res_out, res_out_nxt;
    logic            res_cout, res_cout_nxt;
    logic            res_overflow, res_overflow_nxt;
    logic            busy, busy_nxt;
    logic            win;
    logic [SIZE:0]   prod;

    // Full-width product; only bits [SIZE:0] are kept.
    assign prod = (SIZE + 1)'(PW'(op_a) * PW'(op_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            cur_id       <= 1'b0;
            last         <= 1'b1;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            res_valid    <= 1'b0;
            res_id       <= 1'b0;
            res_out      <= '0;
            res_cout     <= 1'b0;
            res_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            op_a         <= op_a_nxt;
            op_b         <= op_b_nxt;
            cur_id       <= cur_id_nxt;
            last         <= last_nxt;
            gnt0         <= gnt0_nxt;
            gnt1         <= gnt1_nxt;
            res_valid    <= res_valid_nxt;
            res_id       <= res_id_nxt;
            res_out      <= res_out_nxt;
            res_cout     <= res_cout_nxt;
            res_overflow <= res_overflow_nxt;
            busy         <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        op_a_nxt         = op_a;
        op_b_nxt         = op_b;
        cur_id_nxt       = cur_id;
        last_nxt         = last;
        gnt0_nxt         = 1'b0;
        gnt1_nxt         = 1'b0;
        res_valid_nxt    = res_valid;
        res_id_nxt       = res_id;
        res_out_nxt      = res_out;
        res_cout_nxt     = res_cout;
        res_overflow_nxt = res_overflow;
        // On a tie the requester not served last wins.
        win = (bus.req0 && bus.req1) ? ~last : bus.req1;

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    op_a_nxt   = win ? bus.a1 : bus.a0;
                    op_b_nxt   = win ? bus.b1 : bus.b0;
                    cur_id_nxt = win;
                    last_nxt   = win;
                    gnt0_nxt   = ~win;
                    gnt1_nxt   = win;
                    state_nxt  = MUL;
                end
            end
            MUL: begin
                res_out_nxt      = prod[SIZE-1:0];
                res_cout_nxt     = prod[SIZE];
                res_overflow_nxt = (op_a[MSB] == op_b[MSB]) & (op_a[MSB] ^ prod[MSB]);
                res_id_nxt       = cur_id;
                res_valid_nxt    = 1'b1;
                state_nxt        = DONE;
            end
            DONE: begin
                if (bus.res_ack) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.res_valid    = res_valid;
    assign bus.res_id       = res_id;
    assign bus.res_out      = res_out;
    assign bus.res_cout     = res_cout;
    assign bus.res_overflow = res_overflow;
    assign bus.busy         = busy;
endmodule
